parallel_to_serial_tx: RTL

- Parallel-in, serial-out transmitter; the sending end of the team's 4-bit serial-to-parallel shift-register link.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, one bit per bit period. A receiver that shifts in at its LSB therefore reconstructs the word unchanged.
- Flags each active bit period with serial_valid and pulses done when the frame ends.

---
 rtl/serie_paralelo_pkg.sv | 26 ++
 rtl/parallel_to_serial_tx_bit_timer.sv | 36 +++
 rtl/parallel_to_serial_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serie_paralelo_pkg.sv
// serie_paralelo_pkg
// Types and constants shared by the serial/parallel link blocks.
//   tx_state_t     : transmitter FSM states (PARITY is only reachable when
//                    the design is built with PISO_PARITY_EN defined)
//   SP_WIDTH       : default link word width
//   frame_bits()   : number of serial bit periods per frame for a word width
// Optional build macro: PISO_PARITY_EN (adds one even-parity bit per frame).
package serie_paralelo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  localparam int SP_WIDTH = 4;

  function automatic int frame_bits(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/parallel_to_serial_tx_bit_timer.sv
// bit_timer
// Bit-period timer for the serial transmitter. Down-counts from
// CLKS_PER_BIT-1 to 0 and reloads; bit_tick is high on the last clk cycle of
// each bit period.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset (counter cleared to 0)
//   start    : restart the bit period (loads CLKS_PER_BIT-1)
//   bit_tick : terminal count of the current bit period
// With CLKS_PER_BIT=1 the counter stays at 0, so bit_tick is always high.
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt;

  assign bit_tick = (clk_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt <= '0;
    end else if (start || bit_tick) begin
      clk_cnt <= LAST;
    end else begin
      clk_cnt <= clk_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/parallel_to_serial_tx.sv
// parallel_to_serial_tx
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word and sends it
// MSB-first, each bit held for CLKS_PER_BIT clk cycles.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset
//   data_in      : parallel word, sampled only when accepted
//   load_valid   : requester offers data_in
//   load_ready   : transmitter can accept a word (IDLE only)
//   serial_out   : registered serial data
//   serial_valid : serial_out carries a frame bit
//   done         : one-cycle pulse in the first IDLE cycle after a frame
// Handshake: a word is accepted on a rising edge where load_valid and
// load_ready are both high; load_valid while load_ready is low is dropped.
// Optional build macro: PISO_PARITY_EN appends an even-parity bit.
module parallel_to_serial_tx
  import serie_paralelo_pkg::*;
#(
  parameter int WIDTH        = SP_WIDTH,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             done_n;
  logic             serial_out_n;
  logic             serial_valid_n;
  logic             start;
  logic             bit_tick;
`ifdef PISO_PARITY_EN
  logic             parity_reg, parity_n;
`endif

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bit_tick (bit_tick)
  );

  assign load_ready = (state == IDLE);

  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    start     = 1'b0;
`ifdef PISO_PARITY_EN
    parity_n  = parity_reg;
`endif
    case (state)
      IDLE: begin
        if (load_valid) begin
          shift_n   = data_in;
          bit_cnt_n = '0;
          start     = 1'b1;
          state_n   = SHIFT;
`ifdef PISO_PARITY_EN
          parity_n  = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          shift_n = {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            // Wrap explicitly so a non-power-of-two WIDTH never overflows.
            bit_cnt_n = '0;
`ifdef PISO_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = IDLE;
            done_n    = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // Output flops are loaded from the next-state view so serial_out and
    // serial_valid change on the same edge as the state they describe.
    serial_valid_n = (state_n != IDLE);
    serial_out_n   = 1'b0;
    if (state_n == SHIFT) begin
      serial_out_n = shift_n[WIDTH-1];
    end
`ifdef PISO_PARITY_EN
    if (state_n == PARITY) begin
      serial_out_n = parity_n;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      done         <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      shift_reg    <= shift_n;
      bit_cnt      <= bit_cnt_n;
      done         <= done_n;
      serial_out   <= serial_out_n;
      serial_valid <= serial_valid_n;
`ifdef PISO_PARITY_EN
      parity_reg   <= parity_n;
`endif
    end
  end

endmodule
